// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU width and operation encodings
package alu_pkg;

   localparam int WORD_DEFAULT = 64;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_PASS = 4'b0111;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_ADDS = 4'b1010;
   localparam logic [3:0] ALU_SUBS = 4'b1110;

endpackage

// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand, control and result bundle for the ALU
interface alu_if #(
   parameter int WORD = alu_pkg::WORD_DEFAULT
);
   logic [WORD-1:0] a;
   logic [WORD-1:0] b;
   logic [3:0]      ALUCtl;
   logic            FlagWE;
   logic [WORD-1:0] ALUOut;
   logic            Zero;
   logic            Negative;
   logic            Co;
   logic            Overflow;
   logic [3:0]      Flags;

   modport master (
      output a, b, ALUCtl, FlagWE,
      input  ALUOut, Zero, Negative, Co, Overflow, Flags
   );

   modport slave (
      input  a, b, ALUCtl, FlagWE,
      output ALUOut, Zero, Negative, Co, Overflow, Flags
   );
endinterface

// File: rtl/alu_flags_reg.sv
// rtl/alu_flags_reg.sv - 4-bit NZCV condition register, sync reset, load enable
module alu_flags_reg (
   input  logic       clk,
   input  logic       rst,
   input  logic       we,
   input  logic [3:0] d,
   output logic [3:0] q
);

   logic [3:0] flags_d;
   logic [3:0] flags_q;

   always_comb begin
      flags_d = flags_q;
      if (we) begin
         flags_d = d;
      end
   end

   // Reset wins over a simultaneous load.
   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= 4'b0000;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign q = flags_q;

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU with registered NZCV flags
module alu
   import alu_pkg::*;
#(
   parameter int WORD = WORD_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   alu_if.slave bus
);

   logic [WORD-1:0] b_eff;
   logic            carry_in;
   logic [WORD:0]   sum_ext;
   logic [WORD-1:0] result;
   logic            set_cv;
   logic            co;
   logic            ovf;
   logic            zero;
   logic            neg;

   always_comb begin
      // Subtraction shares the adder as a + ~b + 1.
      carry_in = (bus.ALUCtl == ALU_SUB) || (bus.ALUCtl == ALU_SUBS);
      b_eff    = carry_in ? ~bus.b : bus.b;
      sum_ext  = {1'b0, bus.a} + {1'b0, b_eff} + {{WORD{1'b0}}, carry_in};
   end

   always_comb begin
      result = '0;
      set_cv = 1'b0;
      case (bus.ALUCtl)
         ALU_AND:  result = bus.a & bus.b;
         ALU_OR:   result = bus.a | bus.b;
         ALU_ADD:  result = sum_ext[WORD-1:0];
         ALU_SUB:  result = sum_ext[WORD-1:0];
         ALU_PASS: result = bus.b;
         ALU_NOR:  result = ~(bus.a | bus.b);
         ALU_ADDS: begin
            result = sum_ext[WORD-1:0];
            set_cv = 1'b1;
         end
         ALU_SUBS: begin
            result = sum_ext[WORD-1:0];
            set_cv = 1'b1;
         end
         default:  result = '0;
      endcase
   end

   always_comb begin
      zero = (result == '0);
      neg  = result[WORD-1];
      co   = set_cv & sum_ext[WORD];
      ovf  = set_cv & (bus.a[WORD-1] == b_eff[WORD-1]) & (result[WORD-1] != bus.a[WORD-1]);
   end

   assign bus.ALUOut   = result;
   assign bus.Zero     = zero;
   assign bus.Negative = neg;
   assign bus.Co       = co;
   assign bus.Overflow = ovf;

   alu_flags_reg u_flags (
      .clk (clk),
      .rst (rst),
      .we  (bus.FlagWE),
      .d   ({neg, zero, co, ovf}),
      .q   (bus.Flags)
   );

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed self-checking bench for alu
module tb_alu;
   import alu_pkg::*;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   alu_if #(.WORD(64)) bus ();

   alu #(.WORD(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic apply(input logic [3:0] ctl, input logic [63:0] av, input logic [63:0] bv);
      bus.ALUCtl = ctl;
      bus.a      = av;
      bus.b      = bv;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp      = 0;
      n_bad      = 0;
      rst        = 1'b1;
      bus.FlagWE = 1'b0;
      apply(ALU_AND, 64'h0, 64'h0);
      tick();
      check_eq("reset_flags", {60'h0, bus.Flags}, 64'h0);

      // Combinational outputs track inputs while reset is held
      apply(ALU_PASS, 64'h0, 64'h1234);
      check_eq("rst_pass_out", bus.ALUOut, 64'h1234);
      rst = 1'b0;

      apply(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
      check_eq("add_out", bus.ALUOut, 64'h8000_0000_0000_0000);
      check_eq("add_n", {63'h0, bus.Negative}, 64'h1);
      check_eq("add_z", {63'h0, bus.Zero}, 64'h0);
      check_eq("add_v", {63'h0, bus.Overflow}, 64'h0);
      check_eq("add_c", {63'h0, bus.Co}, 64'h0);

      apply(ALU_ADDS, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
      check_eq("adds_out", bus.ALUOut, 64'h8000_0000_0000_0000);
      check_eq("adds_n", {63'h0, bus.Negative}, 64'h1);
      check_eq("adds_v", {63'h0, bus.Overflow}, 64'h1);
      check_eq("adds_c", {63'h0, bus.Co}, 64'h0);
      bus.FlagWE = 1'b1;
      tick();
      bus.FlagWE = 1'b0;
      check_eq("adds_flags", {60'h0, bus.Flags}, 64'h9);

      apply(ALU_SUB, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
      check_eq("sub_out", bus.ALUOut, 64'h8000_0000_0000_0001);
      check_eq("sub_n", {63'h0, bus.Negative}, 64'h1);
      check_eq("sub_z", {63'h0, bus.Zero}, 64'h0);
      check_eq("sub_v", {63'h0, bus.Overflow}, 64'h0);
      check_eq("flags_hold_we0", {60'h0, bus.Flags}, 64'h9);

      apply(ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFD, 64'h3);
      check_eq("add_wrap_out", bus.ALUOut, 64'h0);
      check_eq("add_wrap_z", {63'h0, bus.Zero}, 64'h1);
      check_eq("add_wrap_c", {63'h0, bus.Co}, 64'h0);
      apply(ALU_ADDS, 64'hFFFF_FFFF_FFFF_FFFD, 64'h3);
      check_eq("adds_wrap_c", {63'h0, bus.Co}, 64'h1);
      check_eq("adds_wrap_v", {63'h0, bus.Overflow}, 64'h0);

      apply(ALU_AND, 64'hFFFF_FFFF_FFFF_FFFD, 64'h3);
      check_eq("and_out", bus.ALUOut, 64'h1);
      check_eq("and_z", {63'h0, bus.Zero}, 64'h0);
      apply(ALU_OR, 64'hFFFF_FFFF_FFFF_FFFD, 64'h3);
      check_eq("or_out", bus.ALUOut, 64'hFFFF_FFFF_FFFF_FFFF);
      check_eq("or_n", {63'h0, bus.Negative}, 64'h1);
      apply(ALU_PASS, 64'hFFFF_FFFF_FFFF_FFFD, 64'h3);
      check_eq("pass_out", bus.ALUOut, 64'h3);
      apply(ALU_NOR, 64'hFFFF_FFFF_FFFF_FFFD, 64'h3);
      check_eq("nor_out", bus.ALUOut, 64'h0);
      check_eq("nor_z", {63'h0, bus.Zero}, 64'h1);
      check_eq("nor_n", {63'h0, bus.Negative}, 64'h0);

      // Unlisted code with operands that would otherwise produce carry/overflow
      apply(4'b0011, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
      check_eq("undef_out", bus.ALUOut, 64'h0);
      check_eq("undef_nzcv", {60'h0, bus.Negative, bus.Zero, bus.Co, bus.Overflow}, 64'h4);

      // Reset overrides a simultaneous flag write
      rst        = 1'b1;
      bus.FlagWE = 1'b1;
      apply(ALU_ADDS, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
      tick();
      check_eq("rst_over_we", {60'h0, bus.Flags}, 64'h0);
      rst        = 1'b0;
      bus.FlagWE = 1'b0;

      apply(ALU_SUBS, 64'h0, 64'h1);
      check_eq("subs_neg_out", bus.ALUOut, 64'hFFFF_FFFF_FFFF_FFFF);
      check_eq("subs_neg_c", {63'h0, bus.Co}, 64'h0);
      tick();
      check_eq("subs_hold", {60'h0, bus.Flags}, 64'h0);
      bus.FlagWE = 1'b1;
      tick();
      check_eq("subs_load", {60'h0, bus.Flags}, 64'h8);

      apply(ALU_SUBS, 64'h5, 64'h3);
      check_eq("subs_pos_out", bus.ALUOut, 64'h2);
      check_eq("subs_pos_cv", {62'h0, bus.Co, bus.Overflow}, 64'h2);
      tick();
      check_eq("subs_pos_flags", {60'h0, bus.Flags}, 64'h2);

      apply(ALU_SUBS, 64'h8000_0000_0000_0000, 64'h1);
      check_eq("subs_ovf_cv", {62'h0, bus.Co, bus.Overflow}, 64'h3);
      tick();
      bus.FlagWE = 1'b0;
      check_eq("subs_ovf_flags", {60'h0, bus.Flags}, 64'h3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WORD, default 64, datapath width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 a  input  WORD  operand A.
REQ-005 b  input  WORD  operand B.
REQ-006 ALUCtl  input  4  operation select.
REQ-007 FlagWE  input  1  condition-flag register write enable.
REQ-008 ALUOut  output  WORD  result, combinational.
REQ-009 Zero  output  1  ALUOut == 0, combinational.
REQ-010 Negative  output  1  ALUOut[WORD-1], combinational.
REQ-011 Co  output  1  unsigned carry; flag-setting ops only, combinational.
REQ-012 Overflow  output  1  signed overflow; flag-setting ops only, combinational.
REQ-013 Flags  output  4  registered NZCV, bit3=N, bit2=Z, bit1=C, bit0=V.

Function
REQ-014 ALUCtl encodings SHALL be:
- AND=0000: a&b
- OR=0001: a|b
- ADD=0010: a+b
- SUB=0110: a-b
- PASS=0111: b
- NOR=1100: ~(a|b)
- ADDS=1010: a+b, sets C/V
- SUBS=1110: a-b, sets C/V
REQ-015 Arithmetic SHALL be modulo 2^WORD; SUB/SUBS computed as a + ~b + 1.
REQ-016 ALUOut, Zero, Negative SHALL settle combinationally with zero-cycle latency for every code.
REQ-017 For ADDS, Co SHALL be the carry out of bit WORD-1; for SUBS, Co SHALL be the carry out of a + ~b + 1 (1 = no borrow).
REQ-018 For ADDS/SUBS, Overflow SHALL be 1 iff the effective operand signs match and the result sign differs.
REQ-019 For all non-flag-setting codes (including ADD and SUB), Co and Overflow SHALL be 0.
REQ-020 Unlisted ALUCtl codes SHALL give ALUOut=0, Zero=1, Negative=0, Co=0, Overflow=0.
REQ-021 On a rising clk edge with rst=0 and FlagWE=1, Flags SHALL load {Negative, Zero, Co, Overflow}.
REQ-022 With FlagWE=0, Flags SHALL hold its value.
REQ-023 Flags SHALL change only on clk edges; combinational outputs SHALL not depend on Flags.

Reset
REQ-024 On a rising clk edge with rst=1, Flags SHALL become 4'b0000; rst SHALL take priority over FlagWE.
REQ-025 Reset SHALL not affect the combinational outputs; they track a, b and ALUCtl during reset.

Structure
REQ-026 A shared package/header SHALL hold WORD and the eight ALUCtl encoding constants; decoders and benches use it.
REQ-027 One sub-module, alu_flags_reg (4-bit NZCV register with sync reset and enable), is natural; the rest is one combinational block.

Verification
REQ-028 ADD, a=7FFFFFFFFFFFFFFF, b=1 -> ALUOut=8000000000000000, Negative=1, Zero=0, Overflow=0, Co=0.
REQ-029 ADDS, same operands -> ALUOut=8000000000000000, Negative=1, Overflow=1, Co=0; with FlagWE=1, next edge Flags=4'b1001.
REQ-030 SUB, a=8000000000000000, b=FFFFFFFFFFFFFFFF -> ALUOut=8000000000000001, Negative=1, Zero=0, Overflow=0.
REQ-031 ADD, a=FFFFFFFFFFFFFFFD, b=3 -> ALUOut=0, Zero=1, Co=0; ADDS with same operands -> Co=1, Overflow=0.
REQ-032 Same a/b, logic ops:
- AND -> 1, Zero=0
- OR -> FFFFFFFFFFFFFFFF, Negative=1
- PASS -> 3
- NOR -> 0, Zero=1, Negative=0
REQ-033 Flags=1001, assert rst with FlagWE=1 -> Flags=0000 after one edge; FlagWE=0 with SUBS a=0, b=1 -> Flags unchanged.
